// File: rtl/beep_driver.sv
// Timed piezo buzzer driver: a trig pulse starts 1-15 square-wave beeps separated by silent gaps.
// Optional build macro BEEP_RETRIG_EN lets a trig with nonzero count restart a running sequence.
module beep_driver #(
    parameter int HALF_PERIOD = 12_500,
    parameter int ON_CYC      = 5_000_000,
    parameter int OFF_CYC     = 5_000_000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [3:0] count,
    output logic       buzz,
    output logic       env,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state, state_n;
    logic [3:0]       remaining, remaining_n;
    logic [CNT_W-1:0] phase, phase_n;
    logic [CNT_W-1:0] tone, tone_n;
    logic             buzz_n, env_n, busy_n, done_n;
    logic             start, load;

    assign start = trig && (count != 4'd0);

    // Next-state logic; output registers hold the values for the cycle after the edge.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        phase_n     = phase;
        tone_n      = tone;
        buzz_n      = 1'b0;
        env_n       = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        load        = 1'b0;

        case (state)
            IDLE: begin
                load = start;
            end
            ON: begin
                if (phase == ON_LAST) begin
                    phase_n = '0;
                    tone_n  = '0;
                    if (remaining > 4'd1) begin
                        remaining_n = remaining - 4'd1;
                        state_n     = OFF;
                        busy_n      = 1'b1;
                    end else begin
                        remaining_n = 4'd0;
                        state_n     = IDLE;
                        done_n      = 1'b1;
                    end
                end else begin
                    phase_n = phase + ONE;
                    env_n   = 1'b1;
                    busy_n  = 1'b1;
                    if (tone == HP_LAST) begin
                        tone_n = '0;
                        buzz_n = ~buzz;
                    end else begin
                        tone_n = tone + ONE;
                        buzz_n = buzz;
                    end
                end
            end
            OFF: begin
                busy_n = 1'b1;
                if (phase == OFF_LAST) begin
                    phase_n = '0;
                    tone_n  = '0;
                    state_n = ON;
                    env_n   = 1'b1;
                end else begin
                    phase_n = phase + ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

`ifdef BEEP_RETRIG_EN
        if (state != IDLE && start) begin
            load = 1'b1;
        end
`endif

        // A (re)start always begins a fresh, in-phase first beep.
        if (load) begin
            state_n     = ON;
            remaining_n = count;
            phase_n     = '0;
            tone_n      = '0;
            buzz_n      = 1'b0;
            env_n       = 1'b1;
            busy_n      = 1'b1;
            done_n      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 4'd0;
            phase     <= '0;
            tone      <= '0;
            buzz      <= 1'b0;
            env       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            phase     <= phase_n;
            tone      <= tone_n;
            buzz      <= buzz_n;
            env       <= env_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_beep_driver.sv
// Self-checking bench for beep_driver; expected outputs come from an arithmetic
// schedule model (sequence start cycle + beep count) driven by random and directed stimulus.
module tb_beep_driver;

    localparam int HP   = 2;
    localparam int ONC  = 8;
    localparam int OFFC = 4;
`ifdef BEEP_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [3:0] count;
    logic       buzz, env, busy, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit active   = 1'b0;
    int seq_start = 0;
    int seq_n     = 0;

    always #5 clk = ~clk;

    beep_driver #(
        .HALF_PERIOD(HP),
        .ON_CYC     (ONC),
        .OFF_CYC    (OFFC),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .trig (trig),
        .count(count),
        .buzz (buzz),
        .env  (env),
        .busy (busy),
        .done (done)
    );

    // Expected {buzz,env,busy,done} for cycle c from the sequence schedule.
    function automatic logic [3:0] exp_vec(input int c);
        int  rel, total, r;
        logic b, e;
        if (!active) return 4'b0000;
        rel   = c - seq_start;
        total = seq_n * ONC + (seq_n - 1) * OFFC;
        if (rel < 0 || rel > total) return 4'b0000;
        if (rel == total) return 4'b0001;
        r = rel % (ONC + OFFC);
        e = (r < ONC);
        b = e && (((r / HP) % 2) == 1);
        return {b, e, 1'b1, 1'b0};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
    task automatic step(input logic t, input logic [3:0] n, input logic r);
        logic [3:0] prev;
        @(negedge clk);
        trig  = t;
        count = n;
        rst   = r;
        prev  = exp_vec(cyc);
        @(posedge clk);
        cyc++;
        if (r) begin
            active = 1'b0;
        end else if (t && n != 4'd0 && (!prev[1] || RETRIG)) begin
            active    = 1'b1;
            seq_start = cyc;
            seq_n     = n;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs, expv;
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom % 2), 4'($urandom), 1'b1);
            obs  = {buzz, env, busy, done};
            expv = exp_vec(cyc);
            checks++;
            if (obs !== 4'b0000 || obs !== expv) begin
                $display("FAIL reset cyc=%0d got=%b want=0000", cyc, obs);
                failures++;
            end
        end
        step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_single_beep();
        logic [3:0] obs, expv;
        logic [7:0] pat;
        int done_at, done_cnt;
        pat = '0; done_at = -1; done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step(i == 1, (i == 1) ? 4'd1 : 4'd0, 1'b0);
            obs  = {buzz, env, busy, done};
            expv = exp_vec(cyc);
            checks++;
            if (obs !== expv) begin
                $display("FAIL single_beep i=%0d got=%b want=%b", i, obs, expv);
                failures++;
            end
            if (i <= 8) pat = {pat[6:0], buzz};
            if (done) begin done_at = i; done_cnt++; end
        end
        checks++;
        if (pat !== 8'b0011_0011) begin
            $display("FAIL single_buzz_pattern got=%b want=00110011", pat);
            failures++;
        end
        checks++;
        if (done_at != 9 || done_cnt != 1) begin
            $display("FAIL single_done got_at=%0d cnt=%0d want_at=9 cnt=1", done_at, done_cnt);
            failures++;
        end
    endtask

    task automatic test_three_beeps();
        logic [3:0] obs, expv;
        int busy_cnt, done_at, done_cnt;
        busy_cnt = 0; done_at = -1; done_cnt = 0;
        for (int i = 1; i <= 36; i++) begin
            step(i == 1, (i == 1) ? 4'd3 : 4'd0, 1'b0);
            obs  = {buzz, env, busy, done};
            expv = exp_vec(cyc);
            checks++;
            if (obs !== expv) begin
                $display("FAIL three_beeps i=%0d got=%b want=%b", i, obs, expv);
                failures++;
            end
            if (busy) busy_cnt++;
            if (done) begin done_at = i; done_cnt++; end
        end
        checks++;
        if (busy_cnt != 32 || done_at != 33 || done_cnt != 1) begin
            $display("FAIL three_summary busy=%0d done_at=%0d cnt=%0d want 32/33/1",
                     busy_cnt, done_at, done_cnt);
            failures++;
        end
    endtask

    task automatic test_zero_count();
        logic [3:0] obs;
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            obs = {buzz, env, busy, done};
            checks++;
            if (obs !== 4'b0000 || obs !== exp_vec(cyc)) begin
                $display("FAIL zero_count i=%0d got=%b want=0000", i, obs);
                failures++;
            end
            step(1'b0, 4'($urandom), 1'b0);
        end
    endtask

    task automatic test_trig_while_busy();
        logic [3:0] obs, expv;
        int done_at, done_cnt, want_at;
        done_at = -1; done_cnt = 0;
        want_at = RETRIG ? 26 : 9;
        for (int i = 1; i <= 30; i++) begin
            step(i == 1 || i == 6, (i == 1) ? 4'd1 : 4'd2, 1'b0);
            obs  = {buzz, env, busy, done};
            expv = exp_vec(cyc);
            checks++;
            if (obs !== expv) begin
                $display("FAIL trig_busy i=%0d got=%b want=%b", i, obs, expv);
                failures++;
            end
            if (done) begin
                if (done_at < 0) done_at = i;
                done_cnt++;
            end
        end
        checks++;
        if (done_at != want_at || done_cnt != 1) begin
            $display("FAIL trig_busy_done got_at=%0d cnt=%0d want_at=%0d cnt=1",
                     done_at, done_cnt, want_at);
            failures++;
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] obs, expv;
        int done_at, done_cnt;
        done_at = -1; done_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            step(i == 1 || i == 16, (i == 1) ? 4'd3 : 4'd1, i == 11);
            obs  = {buzz, env, busy, done};
            expv = exp_vec(cyc);
            checks++;
            if (obs !== expv || (i >= 11 && i <= 15 && obs !== 4'b0000)) begin
                $display("FAIL mid_reset i=%0d got=%b want=%b", i, obs, expv);
                failures++;
            end
            if (done) begin done_at = i; done_cnt++; end
        end
        checks++;
        if (done_at != 24 || done_cnt != 1) begin
            $display("FAIL mid_reset_done got_at=%0d cnt=%0d want_at=24 cnt=1", done_at, done_cnt);
            failures++;
        end
    endtask

    task automatic test_random();
        logic [3:0] obs, expv;
        logic t, r;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom % 250) == 0;
            t = ($urandom % 12) == 0;
            step(t, 4'($urandom), r);
            obs  = {buzz, env, busy, done};
            expv = exp_vec(cyc);
            checks++;
            if (obs !== expv) begin
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, expv);
                failures++;
            end
        end
        for (int i = 0; i < 200; i++) step(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        trig  = 1'b0;
        count = 4'd0;
        test_reset();
        test_single_beep();
        test_three_beeps();
        test_zero_count();
        test_trig_while_busy();
        step(1'b0, 4'd0, 1'b0);
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beep_driver.md
# beep_driver

Timed buzzer driver for the stopwatch/clock output side. A single-cycle `trig` pulse, typically a debounced button `pulse` or an alarm/lap event, starts a sequence of 1–15 beeps. Each beep is a square-wave tone of programmable pitch and duration, separated by programmable silent gaps. `buzz` drives the piezo pin directly; `busy` and `done` report status to the control logic.

## Interface
Parameters:
- `HALF_PERIOD`, default 12_500: tone half-period in clk cycles (2 kHz at 50 MHz); must be ≥1.
- `ON_CYC`, default 5_000_000: length of one beep in clk cycles (100 ms at 50 MHz); must be ≥1.
- `OFF_CYC`, default 5_000_000: silent gap between beeps in clk cycles; must be ≥1.
- `CNT_W`, default 24: width of the internal timers; every cycle parameter must be < 2**CNT_W.

Ports:
- `clk` input 1: single system clock; all logic runs on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `trig` input 1: one-cycle start request, synchronous to `clk`.
- `count` input 4: number of beeps, sampled only on the accepted `trig` cycle; 0 means no beep.
- `buzz` output 1: tone output, registered.
- `env` output 1: high during every beep (ON phase), registered.
- `busy` output 1: high from the first ON cycle until the sequence ends.
- `done` output 1: one-cycle pulse when the sequence completes normally.

## Operation
- FSM states: IDLE, ON, OFF.
- IDLE: when `trig`=1 and `count`≠0, latch `count` into the 4-bit `remaining` counter, clear the phase timer and tone timer, set `buzz`=0, and go to ON. When `trig`=1 and `count`=0, do nothing.
- ON: `env`=1 and `busy`=1. The tone timer counts 0..HALF_PERIOD-1; on wrap, `buzz` toggles. The phase timer counts ON_CYC cycles. On the last ON cycle:
  - `remaining`>1: decrement and go to OFF.
  - `remaining`=1: go to IDLE and assert `done` for one cycle.
- OFF: `env`=0, `buzz`=0, `busy`=1. The phase timer counts OFF_CYC cycles, then the FSM enters ON with the tone timer cleared and `buzz`=0. Every beep therefore starts in phase.
- `buzz` is forced to 0 in every state except ON.
- `trig` during ON or OFF is ignored (see Configuration).
- `rst` has priority over everything. On the edge where `rst`=1: state becomes IDLE, all timers and `remaining` clear, and `buzz`, `env`, `busy`, `done` become 0. A `trig` coincident with `rst` is lost.
- Reset value of every output: 0.

## Timing
- `trig` is accepted at edge T.
- First ON cycle is T+1: `busy`=1, `env`=1, `buzz`=0.
- `buzz` first goes high at T+1+HALF_PERIOD, then toggles every HALF_PERIOD cycles while in ON.
- Each ON phase lasts exactly ON_CYC cycles; each OFF phase lasts exactly OFF_CYC cycles.
- Total `busy` time is N·ON_CYC + (N−1)·OFF_CYC cycles for N = `count`.
- `done`=1 on the first cycle after the last ON cycle; `busy`=0 and `env`=0 on that same cycle.
- A new `trig` is accepted on the `done` cycle or later.
- No combinational path from inputs to outputs.

## Configuration
- `BEEP_RETRIG_EN` defined: a `trig` with `count`≠0 during ON or OFF restarts the sequence. `remaining` reloads from `count` and the FSM enters ON on the next cycle, with timers cleared and `buzz`=0. No `done` is issued for the aborted sequence. A `trig` with `count`=0 while busy still does nothing.
- `BEEP_RETRIG_EN` not defined: `trig` is ignored whenever `busy`=1.

## Test plan
Bench parameters: HALF_PERIOD=2, ON_CYC=8, OFF_CYC=4.
- Reset: hold `rst`=1 for 3 cycles with random `trig`/`count` → `buzz`, `env`, `busy`, `done` all 0.
- Single beep: `trig`, `count`=1 at T → `env`=1 for T+1..T+8; `buzz` sequence 0,0,1,1,0,0,1,1; `done`=1 at T+9 only; `busy`=0 at T+9.
- Three beeps: `count`=3 → `env` runs 8 high, 4 low, 8 high, 4 low, 8 high; `busy` high for 32 cycles; each beep's `buzz` starts at 0; exactly one `done`, at T+33.
- Zero count: `trig` with `count`=0 in IDLE → all outputs stay 0 for 50 cycles.
- Trigger while busy: `trig` with `count`=2 at T+5 during a `count`=1 beep.
  - Without macro → ignored; `done` at T+9.
  - With `BEEP_RETRIG_EN` → ON restarts at T+6; no `done` at T+9; two beeps follow; `done` at T+6+20.
- Mid-sequence reset: `rst` at T+10 during a `count`=3 sequence → all outputs 0 from T+11, no `done`. `trig` at T+15 with `count`=1 → normal single beep.
